// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: PC width, 2-bit counter
// encodings and a saturating event-counter increment.
package branch_predictor_pkg;

  localparam int PC_W  = 13;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    SC_SNT = 2'b00,
    SC_WNT = 2'b01,
    SC_WT  = 2'b10,
    SC_ST  = 2'b11
  } sat_ctr_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/branch_predictor_sat_ctr2.sv
// 2-bit saturating direction counter: one step toward strong-taken or
// strong-not-taken depending on the resolved outcome.
module sat_ctr2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != SC_ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != SC_SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, combinational lookup,
// registered update from the execute stage, and hit/mispredict statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  prepc,
  output logic             hit_predict,
  output logic [1:0]       state,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int TAG_W = PC_W - IDX_W;

  logic [ENTRIES-1:0]      valid_q, valid_d;
  logic [ENTRIES-1:0][1:0] ctr_q, ctr_d;
  logic [TAG_W-1:0]        tag_q [ENTRIES];
  logic [PC_W-1:0]         tgt_q [ENTRIES];
  logic [CNT_W-1:0]        hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]        miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit;
  logic [1:0]       upd_ctr, upd_ctr_nxt;
  logic [PC_W-1:0]  upd_tgt;
  logic             mispredict;

  // Fetch-side lookup reads only registered state, so a same-cycle update is invisible.
  assign lk_idx      = pc[IDX_W-1:0];
  assign lk_tag      = pc[PC_W-1:IDX_W];
  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign hit_predict = lk_hit;
  assign prepc       = lk_hit ? tgt_q[lk_idx] : '0;
  assign state       = lk_hit ? ctr_q[lk_idx] : SC_SNT;

  assign upd_idx = upd_pc[IDX_W-1:0];
  assign upd_tag = upd_pc[PC_W-1:IDX_W];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_ctr = ctr_q[upd_idx];
  assign upd_tgt = tgt_q[upd_idx];

  // A miss implicitly predicted not-taken; a taken hit also needs the right target.
  assign mispredict = ((upd_hit & upd_ctr[1]) != upd_taken) ||
                      (upd_hit && upd_taken && (upd_tgt != upd_target));

  sat_ctr2 u_sat_ctr2 (
    .ctr_i   (upd_ctr),
    .taken_i (upd_taken),
    .ctr_o   (upd_ctr_nxt)
  );

  always_comb begin
    valid_d    = valid_q;
    ctr_d      = ctr_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (upd_valid) begin
      if (upd_hit) begin
        ctr_d[upd_idx] = upd_ctr_nxt;
        hit_cnt_d      = sat_inc(hit_cnt_q);
      end else if (upd_taken) begin
        valid_d[upd_idx] = 1'b1;
        ctr_d[upd_idx]   = SC_WT;
      end
      if (mispredict) miss_cnt_d = sat_inc(miss_cnt_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      valid_q    <= '0;
      ctr_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      ctr_q      <= ctr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // NOTE: tag/target arrays carry no reset; the valid bits gate every use of them.
  always_ff @(posedge CLK) begin
    if (upd_valid && upd_taken) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= upd_target;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule
